alu_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle datapath ALU. Accepts one operation per transfer on a valid/ready input port and returns a registered result with Zero/CarryOut/Overflow flags on a valid/ready output port. It adds XOR, shifts, an error flag for illegal opcodes, and an optional iterative multiplier. It sits between the decode stage and writeback, and can be reused standalone under the existing interface-based bench.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_pipe_if.sv | 29 ++
 rtl/alu_mul_seq.sv | 47 ++++
 rtl/alu_pipe.sv | 178 +++++++++++++++++
 tb/tb_alu_pipe.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode/state types and opcode legality for the pipelined ALU.
// Legality of MUL depends on ALU_PIPE_MUL_EN.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_XOR = 4'b0011,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SRA = 4'b1010,
        OP_NOR = 4'b1100,
        OP_MUL = 4'b1110
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic is_legal(alu_op_e op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOR,
            OP_ADD, OP_SUB, OP_SLT,
            OP_SLL, OP_SRL, OP_SRA: return 1'b1;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Valid/ready operation and result channels of alu_pipe.
// master = producer/consumer side, slave = the ALU itself.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUCntl;
    logic             CarryIn;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUOut;
    logic             Zero;
    logic             CarryOut;
    logic             Overflow;
    logic             Err;

    modport master (
        output in_valid, A, B, ALUCntl, CarryIn, out_ready,
        input  in_ready, out_valid, ALUOut, Zero, CarryOut, Overflow, Err
    );

    modport slave (
        input  in_valid, A, B, ALUCntl, CarryIn, out_ready,
        output in_ready, out_valid, ALUOut, Zero, CarryOut, Overflow, Err
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier, one partial product per step; only built with ALU_PIPE_MUL_EN.
// product already includes the pending step, so the final add needs no extra cycle.
`ifdef ALU_PIPE_MUL_EN
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int SW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [SW-1:0]      steps;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            steps  <= '0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            steps  <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            steps  <= steps + 1'b1;
        end
    end

    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = (steps == SW'(WIDTH - 1));
endmodule
`endif

// File: rtl/alu_pipe.sv
// Handshaked ALU: registered result and Zero/CarryOut/Overflow/Err flags.
// `define ALU_PIPE_MUL_EN adds the iterative MUL opcode and BUSY state.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       reset,
    alu_pipe_if.slave bus
);
    alu_op_e          op;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic             ovf_add;
    logic             ovf_sub;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic             res_err;
    logic             out_free;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_c;
    logic             load_v;
    logic             load_err;
    logic [WIDTH-1:0] alu_out;
    logic             zero_q;
    logic             carry_q;
    logic             ovf_q;
    logic             err_q;
    logic             valid_q;

    assign op       = alu_op_e'(bus.ALUCntl);
    assign sh       = bus.B[SHW-1:0];
    assign out_free = !valid_q || bus.out_ready;

    // SLT takes the sign of the true difference: sum sign corrected by overflow.
    always_comb begin
        sum_add = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.CarryIn};
        sum_sub = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
        ovf_add = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_add[WIDTH-1] != bus.A[WIDTH-1]);
        ovf_sub = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sum_sub[WIDTH-1] != bus.A[WIDTH-1]);
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = !is_legal(op);
        case (op)
            OP_AND: res = bus.A & bus.B;
            OP_OR:  res = bus.A | bus.B;
            OP_XOR: res = bus.A ^ bus.B;
            OP_NOR: res = ~(bus.A | bus.B);
            OP_ADD: begin
                res   = sum_add[WIDTH-1:0];
                res_c = sum_add[WIDTH];
                res_v = ovf_add;
            end
            OP_SUB: begin
                res   = sum_sub[WIDTH-1:0];
                res_c = sum_sub[WIDTH];
                res_v = ovf_sub;
            end
            OP_SLT: res = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ ovf_sub};
            OP_SLL: res = bus.A << sh;
            OP_SRL: res = bus.A >> sh;
            OP_SRA: res = $signed(bus.A) >>> sh;
            default: res = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    state_e             state;
    logic [SHW-1:0]     counter;
    logic               mul_start;
    logic               mul_step;
    logic               mul_done;
    logic               mul_finish;
    logic [2*WIDTH-1:0] product;

    assign bus.in_ready = (state == IDLE) && out_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_start    = accept && (op == OP_MUL);
    assign mul_step     = (state == BUSY) && (counter != '0);
    assign mul_finish   = (state == BUSY) && (counter == '0) && mul_done && out_free;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .step    (mul_step),
        .a       (bus.A),
        .b       (bus.B),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        load     = (accept && (op != OP_MUL)) || mul_finish;
        load_res = res;
        load_c   = res_c;
        load_v   = res_v;
        load_err = res_err;
        if (mul_finish) begin
            load_res = product[WIDTH-1:0];
            load_c   = |product[2*WIDTH-1:WIDTH];
            load_v   = 1'b0;
            load_err = 1'b0;
        end
    end

    // BUSY parks at counter 0 until the result register can take the product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        state   <= BUSY;
                        counter <= SHW'(WIDTH - 1);
                    end
                end
                BUSY: begin
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else if (mul_finish) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign bus.in_ready = out_free;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        load     = accept;
        load_res = res;
        load_c   = res_c;
        load_v   = res_v;
        load_err = res_err;
    end
`endif

    // A load wins over a consume on the same edge, giving one result per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            alu_out <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            alu_out <= load_res;
            zero_q  <= !load_err && (load_res == '0);
            carry_q <= load_c;
            ovf_q   <= load_v;
            err_q   <= load_err;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.ALUOut    = alu_out;
    assign bus.Zero      = zero_q;
    assign bus.CarryOut  = carry_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Err       = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=32: directed cases, backpressure,
// reset mid-operation and randomized ops against an arithmetic reference model.
module tb_alu_pipe;
    localparam int W = 32;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_SRA = 4'b1010;
    localparam logic [3:0] C_MUL = 4'b1110;
    localparam logic [3:0] C_BAD = 4'b1111;

`ifdef ALU_PIPE_MUL_EN
    localparam int MUL_LAT = W;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        logic         e;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   failures;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic [W-1:0] res, logic z, logic c, logic v, logic e);
        exp_t r;
        r.res = res;
        r.z   = z;
        r.c   = c;
        r.v   = v;
        r.e   = e;
        return r;
    endfunction

    // Reference model from the opcode rules, using wide integer arithmetic.
    function automatic exp_t refModel(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic cin);
        exp_t r;
        longint unsigned wide;
        longint sw;
        int sh;
        r  = '0;
        sh = int'(b[4:0]);
        case (op)
            4'b0000: r.res = a & b;
            4'b0001: r.res = a | b;
            4'b0011: r.res = a ^ b;
            4'b1100: r.res = ~(a | b);
            4'b0010: begin
                wide  = 64'(a) + 64'(b) + 64'(cin);
                r.res = wide[W-1:0];
                r.c   = wide[W];
                sw    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
                r.v   = (sw != longint'($signed(r.res)));
            end
            4'b0110: begin
                r.res = a - b;
                r.c   = (a >= b);
                sw    = longint'($signed(a)) - longint'($signed(b));
                r.v   = (sw != longint'($signed(r.res)));
            end
            4'b0111: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: r.res = a << sh;
            4'b1001: r.res = a >> sh;
            4'b1010: r.res = $signed(a) >>> sh;
`ifdef ALU_PIPE_MUL_EN
            4'b1110: begin
                wide  = 64'(a) * 64'(b);
                r.res = wide[W-1:0];
                r.c   = (wide[63:32] != 32'd0);
            end
`endif
            default: r.e = 1'b1;
        endcase
        if (!r.e) r.z = (r.res == '0);
        return r;
    endfunction

    task automatic checkBit(input string tag, input logic got, input logic expv);
        tests++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, got, expv);
        end
    endtask

    task automatic checkInt(input string tag, input int got, input int expv);
        tests++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Vector layout: {out_valid, ALUOut, Zero, CarryOut, Overflow, Err}.
    task automatic checkResult(input string tag, input logic [W+4:0] expv);
        logic [W+4:0] got;
        got = {bus.out_valid, bus.ALUOut, bus.Zero, bus.CarryOut, bus.Overflow, bus.Err};
        tests++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s: got v=%b out=%h z=%b c=%b o=%b e=%b expected v=%b out=%h z=%b c=%b o=%b e=%b",
                   tag, got[W+4], got[W+3:4], got[3], got[2], got[1], got[0],
                   expv[W+4], expv[W+3:4], expv[3], expv[2], expv[1], expv[0]);
        end
    endtask

    // Presents one op, waits (bounded) for in_ready, returns #1 after the accept edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
        int waitCycles;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ALUCntl  = op;
        bus.A        = a;
        bus.B        = b;
        bus.CarryIn  = cin;
        waitCycles   = 0;
        while (!bus.in_ready && waitCycles < 100) begin
            @(negedge clk);
            waitCycles++;
        end
        checkBit("accept_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges from accept to load; in_ready must stay low while waiting.
    task automatic checkOutput(input string tag, input exp_t e, input int expLatency);
        int   cyc;
        logic readySeen;
        cyc       = 0;
        readySeen = 1'b0;
        while (!bus.out_valid && cyc < 200) begin
            if (bus.in_ready) readySeen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        checkInt({tag, "_latency"}, cyc, expLatency);
        if (expLatency > 0) checkBit({tag, "_busy_ready"}, readySeen, 1'b0);
        checkResult(tag, {1'b1, e});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        exp_t held;
        logic [3:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic cin;

        tests         = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.ALUCntl   = 4'b0000;
        bus.CarryIn   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkResult("reset_state", '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkBit("ready_after_reset", bus.in_ready, 1'b1);

        // Directed single-cycle cases
        applyStimulus(C_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        checkOutput("add_ovf", mk(32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0), 0);
        applyStimulus(C_SUB, 32'd5, 32'd5, 1'b0);
        checkOutput("sub_zero", mk(32'd0, 1'b1, 1'b1, 1'b0, 1'b0), 0);
        applyStimulus(C_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
        checkOutput("slt_neg", mk(32'd1, 1'b0, 1'b0, 1'b0, 1'b0), 0);
        applyStimulus(C_SRA, 32'h8000_0000, 32'd4, 1'b0);
        checkOutput("sra", mk(32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0), 0);
        applyStimulus(C_BAD, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        checkOutput("illegal", mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b1), 0);
        applyStimulus(C_ADD, 32'hFFFF_FFFF, 32'd0, 1'b1);
        checkOutput("add_cin_wrap", mk(32'd0, 1'b1, 1'b1, 1'b0, 1'b0), 0);

`ifdef ALU_PIPE_MUL_EN
        applyStimulus(C_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0);
        checkOutput("mul_hi", mk(32'd0, 1'b1, 1'b1, 1'b0, 1'b0), MUL_LAT);
        applyStimulus(C_MUL, 32'd7, 32'd6, 1'b0);
        checkOutput("mul_7x6", mk(32'd42, 1'b0, 1'b0, 1'b0, 1'b0), MUL_LAT);
`else
        applyStimulus(C_MUL, 32'd7, 32'd6, 1'b0);
        checkOutput("mul_disabled", mk(32'd0, 1'b0, 1'b0, 1'b0, 1'b1), 0);
`endif

        // Backpressure: result held, second op stalled until out_ready
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        applyStimulus(C_ADD, 32'd10, 32'd20, 1'b0);
        held = mk(32'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_add", held, 0);
        bus.in_valid = 1'b1;
        bus.ALUCntl  = C_AND;
        bus.A        = 32'h0000_F0F0;
        bus.B        = 32'h0000_FF00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkBit("bp_ready_low", bus.in_ready, 1'b0);
            checkResult("bp_hold", {1'b1, held});
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        checkBit("bp_ready_high", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkResult("bp_and", {1'b1, mk(32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0)});

        // Random back-to-back single-cycle ops at one per cycle
        for (int i = 0; i < 40; i++) begin
            do op = 4'($urandom_range(0, 15)); while (op == C_MUL);
            a   = $urandom;
            b   = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 40));
            cin = 1'($urandom_range(0, 1));
            e   = refModel(op, a, b, cin);
            bus.in_valid = 1'b1;
            bus.ALUCntl  = op;
            bus.A        = a;
            bus.B        = b;
            bus.CarryIn  = cin;
            #1;
            checkBit("burst_ready", bus.in_ready, 1'b1);
            @(posedge clk);
            #1;
            checkResult("burst", {1'b1, e});
        end
        bus.in_valid = 1'b0;

`ifdef ALU_PIPE_MUL_EN
        for (int i = 0; i < 4; i++) begin
            a = (i < 2) ? $urandom : 32'($urandom_range(0, 65535));
            b = (i < 2) ? $urandom : 32'($urandom_range(0, 65535));
            applyStimulus(C_MUL, a, b, 1'b0);
            checkOutput("mul_rand", refModel(C_MUL, a, b, 1'b0), MUL_LAT);
        end

        // Reset 10 cycles into a multiply
        applyStimulus(C_MUL, 32'h1234_5678, 32'h0000_9ABC, 1'b0);
        repeat (10) @(posedge clk);
        #1;
`else
        // Reset with an unconsumed result pending
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
`endif
        reset = 1'b1;
        #1;
        checkResult("reset_mid", '0);
        @(negedge clk);
        @(negedge clk);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkBit("ready_after_mid_reset", bus.in_ready, 1'b1);
        checkResult("idle_after_mid_reset", '0);
        applyStimulus(C_ADD, 32'd2, 32'd3, 1'b0);
        checkOutput("add_after_reset", mk(32'd5, 1'b0, 1'b0, 1'b0, 1'b0), 0);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
